axi_reg_arbiter: RTL and testbench

Two-port request scheduler in front of the AXI register slave. Accepts simple single-word read/write requests from two on-chip requesters (e.g. counter core and debug/host port), arbitrates between them, and issues exactly one AXI transaction at a time on its master port, returning read data and completion status to the winning requester.

---
 rtl/axi_reg_pkg.sv | 42 ++++
 rtl/axi_reg_arbiter_rr_arb2.sv | 42 ++++
 rtl/axi_reg_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_axi_reg_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_reg_pkg.sv
`default_nettype none
// ============================================================================
// axi_reg_pkg : shared state, request and response types for axi_reg_arbiter
// Rev 1.0
// ============================================================================
package axi_reg_pkg;

  localparam int N_REGS    = 8;
  localparam int REG_IDX_W = $clog2(N_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } arb_state_e;

  typedef struct packed {
    logic                 we;
    logic [REG_IDX_W-1:0] idx;
    logic [31:0]          wdata;
  } reg_req_t;

  // Anything other than a plain OKAY is reported to the requester as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic e;
    case (resp)
      RESP_OKAY:                             e = 1'b0;
      RESP_EXOKAY, RESP_SLVERR, RESP_DECERR: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_reg_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-requester grant logic with priority pointer
// Build option ARB_RR_EN: round-robin pointer; undefined = fixed priority to 0.
// Rev 1.0
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       areset,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       adv_id,
  output logic [1:0] gnt
);

`ifdef ARB_RR_EN
  logic prio_q;
  logic prio_d;

  // After serving requester i, requester 1-i gets priority on the next tie.
  always_comb begin
    prio_d = prio_q;
    if (adv) prio_d = ~adv_id;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, areset, adv, adv_id};
  assign gnt       = {req[1] & ~req[0], req[0]};
`endif

endmodule
`default_nettype wire

// File: rtl/axi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// axi_reg_arbiter : schedules single-word requests from two requesters onto
// one AXI master port. Build option ARB_RR_EN selects round-robin arbitration.
// Rev 1.0
// ============================================================================
module axi_reg_arbiter
  import axi_reg_pkg::*;
#(
  parameter logic [3:0] FIXED_WSTRB = 4'hF
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [5:0]  addr_i,
  input  logic [63:0] wdata_i,
  output logic [1:0]  done_o,
  output logic [1:0]  err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [31:0] rdata_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

  arb_state_e  state_q,   state_d;
  reg_req_t    req_q,     req_d;
  logic        win_q,     win_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q,  wvalid_d;
  logic        bready_q,  bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q,  rready_d;
  logic [1:0]  done_q,    done_d;
  logic [1:0]  err_q,     err_d;
  logic [31:0] rdata_q,   rdata_d;

  logic [1:0]  gnt;
  logic        adv;

  rr_arb2 u_arb (
    .clk    (clk),
    .areset (areset),
    .req    (req_i),
    .adv    (adv),
    .adv_id (win_q),
    .gnt    (gnt)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    win_d     = win_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    done_d    = 2'b00;
    err_d     = 2'b00;
    rdata_d   = rdata_q;
    adv       = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          win_d       = gnt[1];
          req_d.we    = gnt[1] ? we_i[1] : we_i[0];
          req_d.idx   = gnt[1] ? addr_i[2*REG_IDX_W-1:REG_IDX_W] : addr_i[REG_IDX_W-1:0];
          req_d.wdata = gnt[1] ? wdata_i[63:32] : wdata_i[31:0];
          if (req_d.we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end

      // AW and W complete independently; leave only once both have been taken.
      WADDR: begin
        awvalid_d = awvalid_q & ~awready_i;
        wvalid_d  = wvalid_q & ~wready_i;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end

      WRESP: begin
        if (bvalid_i) begin
          bready_d      = 1'b0;
          done_d[win_q] = 1'b1;
          err_d[win_q]  = resp_is_err(bresp_i);
          state_d       = DONE;
        end
      end

      RADDR: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end

      RDATA: begin
        if (rvalid_i) begin
          rready_d      = 1'b0;
          rdata_d       = rdata_i;
          done_d[win_q] = 1'b1;
          state_d       = DONE;
        end
      end

      DONE: begin
        adv     = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      win_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      win_q     <= win_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Address and data come straight from the latched request, so they stay
  // stable for the whole transaction regardless of requester inputs.
  assign awaddr_o  = {{(32-REG_IDX_W){1'b0}}, req_q.idx};
  assign araddr_o  = {{(32-REG_IDX_W){1'b0}}, req_q.idx};
  assign wdata_o   = req_q.wdata;
  assign wstrb_o   = req_q.we ? FIXED_WSTRB : 4'h0;
  assign awvalid_o = awvalid_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// tb_axi_reg_arbiter : randomized bench with AXI slave model and request-level
// reference model for axi_reg_arbiter (honours ARB_RR_EN if defined).
// Rev 1.0
// ============================================================================
module tb_axi_reg_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        areset;
  logic [1:0]  req_i, we_i;
  logic [5:0]  addr_i;
  logic [63:0] wdata_i;
  logic [1:0]  done_o, err_o;
  logic [31:0] rdata_o;
  logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i;
  logic        awvalid_o, awready_i, wvalid_o, wready_i;
  logic [3:0]  wstrb_o;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;

  always #5 clk = ~clk;

  axi_reg_arbiter dut (
    .clk       (clk),
    .areset    (areset),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .done_o    (done_o),
    .err_o     (err_o),
    .rdata_o   (rdata_o),
    .awaddr_o  (awaddr_o),
    .awvalid_o (awvalid_o),
    .awready_i (awready_i),
    .wdata_o   (wdata_o),
    .wstrb_o   (wstrb_o),
    .wvalid_o  (wvalid_o),
    .wready_i  (wready_i),
    .bresp_i   (bresp_i),
    .bvalid_i  (bvalid_i),
    .bready_o  (bready_o),
    .araddr_o  (araddr_o),
    .arvalid_o (arvalid_o),
    .arready_i (arready_i),
    .rdata_i   (rdata_i),
    .rvalid_i  (rvalid_i),
    .rready_o  (rready_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // ---------------- slave model ----------------
  logic [31:0] slave_mem [8];
  int  cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [1:0] cfg_bresp = 2'b00;
  bit  rand_dly = 1'b0, rand_resp = 1'b0;
  int  aw_c, w_c, b_c, ar_c, r_c;
  bit  aw_armed, w_armed, ar_armed, have_aw, have_w, wr_pend, rd_pend;
  bit  hs_aw, hs_w, hs_b, hs_ar, hs_r;
  int  n_aw_hs, n_w_hs, n_b_hs, n_ar_hs, n_r_hs, aw_vcyc, w_vcyc;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;
  logic [1:0]  last_bresp;

  function automatic int pick_dly(input int base);
    return rand_dly ? int'($urandom_range(0, 2)) : base;
  endfunction

  task automatic clear_stats();
    n_aw_hs = 0; n_w_hs = 0; n_b_hs = 0; n_ar_hs = 0; n_r_hs = 0;
    aw_vcyc = 0; w_vcyc = 0;
  endtask

  task automatic slave_idle();
    awready_i = 1'b0; wready_i = 1'b0; arready_i = 1'b0;
    bvalid_i = 1'b0; rvalid_i = 1'b0; bresp_i = 2'b00; rdata_i = '0;
    aw_armed = 0; w_armed = 0; ar_armed = 0; have_aw = 0; have_w = 0;
    wr_pend = 0; rd_pend = 0;
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    last_bresp = 2'b00;
    clear_stats();
  endtask

  // Handshakes seen at a negedge complete on the following posedge.
  initial begin
    slave_idle();
    forever begin
      @(negedge clk);
      if (!areset) begin
        slave_idle();
        continue;
      end
      if (hs_aw) begin have_aw = 1'b1; aw_armed = 1'b0; end
      if (hs_w)  begin have_w  = 1'b1; w_armed  = 1'b0; end
      if (have_aw && have_w) begin
        slave_mem[last_awaddr[2:0]] = last_wdata;
        have_aw = 1'b0; have_w = 1'b0; wr_pend = 1'b1;
        b_c = pick_dly(cfg_b_dly);
      end
      if (hs_b) bvalid_i = 1'b0;
      if (hs_ar) begin ar_armed = 1'b0; rd_pend = 1'b1; r_c = pick_dly(cfg_r_dly); end
      if (hs_r) rvalid_i = 1'b0;

      awready_i = 1'b0;
      if (awvalid_o) begin
        aw_vcyc++;
        if (!aw_armed) begin aw_c = pick_dly(cfg_aw_dly); aw_armed = 1'b1; end
        if (aw_c == 0) awready_i = 1'b1; else aw_c--;
      end
      wready_i = 1'b0;
      if (wvalid_o) begin
        w_vcyc++;
        if (!w_armed) begin w_c = pick_dly(cfg_w_dly); w_armed = 1'b1; end
        if (w_c == 0) wready_i = 1'b1; else w_c--;
      end
      arready_i = 1'b0;
      if (arvalid_o) begin
        if (!ar_armed) begin ar_c = pick_dly(cfg_ar_dly); ar_armed = 1'b1; end
        if (ar_c == 0) arready_i = 1'b1; else ar_c--;
      end
      if (wr_pend && !bvalid_i) begin
        if (b_c == 0) begin
          bvalid_i = 1'b1;
          if (rand_resp)
            bresp_i = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          else
            bresp_i = cfg_bresp;
          last_bresp = bresp_i;
          wr_pend = 1'b0;
        end else b_c--;
      end
      if (rd_pend && !rvalid_i) begin
        if (r_c == 0) begin
          rvalid_i = 1'b1;
          rdata_i  = slave_mem[last_araddr[2:0]];
          rd_pend  = 1'b0;
        end else r_c--;
      end

      hs_aw = awvalid_o && awready_i;
      hs_w  = wvalid_o && wready_i;
      hs_ar = arvalid_o && arready_i;
      hs_b  = bvalid_i && bready_o;
      hs_r  = rvalid_i && rready_o;
      if (hs_aw) begin n_aw_hs++; last_awaddr = awaddr_o; end
      if (hs_w)  begin n_w_hs++;  last_wdata = wdata_o; last_wstrb = wstrb_o; end
      if (hs_ar) begin n_ar_hs++; last_araddr = araddr_o; end
      if (hs_b)  n_b_hs++;
      if (hs_r)  n_r_hs++;
    end
  end

  // ---------------- requesters and reference model ----------------
  logic [31:0] ref_mem [8];
  logic [1:0]  act, cont;
  logic        op_we  [2];
  logic [2:0]  op_idx [2];
  logic [31:0] op_wd  [2];
  int          ptr_m, last_w, lat;

  function automatic int exp_winner(input logic [1:0] c);
    if (c == 2'b11) return RR ? ptr_m : 0;
    return c[1] ? 1 : 0;
  endfunction

  task automatic drive_reqs();
    req_i   = act;
    we_i    = {op_we[1], op_we[0]};
    addr_i  = {op_idx[1], op_idx[0]};
    wdata_i = {op_wd[1], op_wd[0]};
  endtask

  task automatic new_op(input int i);
    op_we[i]  = 1'($urandom_range(0, 1));
    op_idx[i] = 3'($urandom_range(0, 7));
    op_wd[i]  = $urandom();
  endtask

  task automatic handle_done();
    int w;
    logic [1:0] exp_err;
    w = exp_winner(cont);
    last_w = w;
    check_eq("grant", 64'(done_o), 64'(2'b01 << w));
    exp_err = 2'b00;
    if (op_we[w]) exp_err[w] = (last_bresp != 2'b00);
    check_eq("err", 64'(err_o), 64'(exp_err));
    if (op_we[w]) begin
      check_eq("aw_handshakes", 64'(n_aw_hs), 64'(1));
      check_eq("w_handshakes", 64'(n_w_hs), 64'(1));
      check_eq("b_handshakes", 64'(n_b_hs), 64'(1));
      check_eq("awaddr", 64'(last_awaddr), 64'(op_idx[w]));
      check_eq("wdata", 64'(last_wdata), 64'(op_wd[w]));
      check_eq("wstrb", 64'(last_wstrb), 64'(4'hF));
      ref_mem[op_idx[w]] = op_wd[w];
    end else begin
      check_eq("ar_handshakes", 64'(n_ar_hs), 64'(1));
      check_eq("r_handshakes", 64'(n_r_hs), 64'(1));
      check_eq("araddr", 64'(last_araddr), 64'(op_idx[w]));
      check_eq("rdata", 64'(rdata_o), 64'(ref_mem[op_idx[w]]));
    end
    if (RR) ptr_m = (w == 0) ? 1 : 0;
  endtask

  task automatic run_one(output int cyc);
    cont = act;
    clear_stats();
    drive_reqs();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done_o == 2'b00 && cyc < 200);
    if (done_o == 2'b00) begin
      check_eq("done_timeout", 64'(cyc), 64'(0));
      summary();
      $finish;
    end
    handle_done();
  endtask

  task automatic go_idle();
    act = 2'b00;
    drive_reqs();
    @(negedge clk);
    check_eq("done_single_pulse", 64'(done_o), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    summary();
    $finish;
  end

  initial begin
    int n;
    areset = 1'b0;
    act = 2'b00; cont = 2'b00; ptr_m = 0; last_w = 0;
    for (int i = 0; i < 2; i++) begin op_we[i] = 1'b0; op_idx[i] = '0; op_wd[i] = '0; end
    for (int i = 0; i < 8; i++) begin ref_mem[i] = $urandom(); slave_mem[i] = ref_mem[i]; end
    drive_reqs();
    repeat (3) @(negedge clk);

    check_eq("rst_valids", 64'({awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}), 64'(0));
    check_eq("rst_done", 64'(done_o), 64'(0));
    check_eq("rst_err", 64'(err_o), 64'(0));
    check_eq("rst_rdata", 64'(rdata_o), 64'(0));
    check_eq("rst_awaddr", 64'(awaddr_o), 64'(0));
    check_eq("rst_araddr", 64'(araddr_o), 64'(0));
    check_eq("rst_wdata", 64'(wdata_o), 64'(0));
    check_eq("rst_wstrb", 64'(wstrb_o), 64'(0));
    areset = 1'b1;
    @(negedge clk);

    // Requester 0 writes, requester 1 reads it back, zero-wait slave.
    op_we[0] = 1'b1; op_idx[0] = 3'd3; op_wd[0] = 32'hDEADBEEF; act = 2'b01;
    run_one(lat);
    check_eq("wr_latency", 64'(lat), 64'(3));
    go_idle();
    op_we[1] = 1'b0; op_idx[1] = 3'd3; act = 2'b10;
    run_one(lat);
    check_eq("rd_latency", 64'(lat), 64'(3));
    check_eq("rd_deadbeef", 64'(rdata_o), 64'(32'hDEADBEEF));
    go_idle();

    // Both requesters held high, each writing its own index.
    op_we[0] = 1'b1; op_idx[0] = 3'd1; op_wd[0] = $urandom();
    op_we[1] = 1'b1; op_idx[1] = 3'd2; op_wd[1] = $urandom();
    act = 2'b11;
    for (int k = 0; k < 4; k++) begin
      run_one(lat);
      check_eq("contend_order", 64'(done_o), RR ? 64'((k % 2 == 0) ? 2'b01 : 2'b10) : 64'(2'b01));
    end
    go_idle();

    // AW accepted late, W immediately.
    cfg_aw_dly = 3;
    op_we[0] = 1'b1; op_idx[0] = 3'd4; op_wd[0] = $urandom(); act = 2'b01;
    run_one(lat);
    check_eq("awvalid_cycles", 64'(aw_vcyc), 64'(4));
    check_eq("wvalid_cycles", 64'(w_vcyc), 64'(1));
    cfg_aw_dly = 0;
    go_idle();

    // SLVERR on a write from requester 1.
    cfg_bresp = 2'b10;
    op_we[1] = 1'b1; op_idx[1] = 3'd7; op_wd[1] = $urandom(); act = 2'b10;
    run_one(lat);
    check_eq("err_with_done", 64'(err_o), 64'(2'b10));
    cfg_bresp = 2'b00;
    go_idle();

    // Reset while waiting for B. Write data equals the stored word so the
    // slave's memory is the same whether or not its write landed.
    cfg_b_dly = 20;
    op_we[0] = 1'b1; op_idx[0] = 3'd5; op_wd[0] = ref_mem[5]; act = 2'b01;
    cont = act;
    drive_reqs();
    n = 0;
    while (!bready_o && n < 20) begin @(negedge clk); n++; end
    check_eq("reach_wresp", 64'(bready_o), 64'(1));
    #2 areset = 1'b0;
    #1;
    check_eq("rst_mid_valids", 64'({awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}), 64'(0));
    check_eq("rst_mid_done", 64'(done_o), 64'(0));
    act = 2'b00;
    drive_reqs();
    repeat (2) @(negedge clk);
    areset = 1'b1;
    ptr_m = 0;
    cfg_b_dly = 0;
    @(negedge clk);
    op_we[0] = 1'b1; op_idx[0] = 3'd6; op_wd[0] = 32'h12345678; act = 2'b01;
    run_one(lat);
    check_eq("post_rst_wr_latency", 64'(lat), 64'(3));
    go_idle();
    op_we[0] = 1'b0; act = 2'b01;
    run_one(lat);
    check_eq("post_rst_rdata", 64'(rdata_o), 64'(32'h12345678));
    go_idle();

    // Randomized traffic with random slave delays and responses.
    rand_dly = 1'b1;
    rand_resp = 1'b1;
    new_op(0); new_op(1);
    act = 2'b11;
    for (int t = 0; t < 80; t++) begin
      run_one(lat);
      if ($urandom_range(0, 3) != 0) new_op(last_w);
      else act[last_w] = 1'b0;
      if (act == 2'b00) begin
        drive_reqs();
        repeat ($urandom_range(1, 3)) @(negedge clk);
        act = 2'($urandom_range(1, 3));
        new_op(0); new_op(1);
      end
    end
    act = 2'b00;
    drive_reqs();
    repeat (3) @(negedge clk);

    summary();
    $finish;
  end

endmodule
`default_nettype wire
